bist_misr_cmp: RTL and testbench
================================

BIST_MISR_CMP -- requirements
Module: bist_misr_cmp

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset. Clock and reset SHALL be named as in the rest of the codebase: clk and reset_l.
REQ-002 SHALL have parameter CHAIN_LEN, default 247: scan-chain length in bits per pattern.
REQ-003 SHALL have parameter NUM_TESTS, default 256: patterns per BIST run.
REQ-004 SHALL have parameter GOLDEN, default 32'h5A17_C3E9: expected final signature.
REQ-005 SHALL have these ports:
- clk  in  1  rising-edge clock
- reset_l  in  1  asynchronous active-low reset
- init  in  1  synchronous clear of signature, counters and verdict
- shift  in  1  capture scan_out and advance the bit counter this cycle
- scan_out  in  1  serial response bit from the circuit under test
- done  in  1  end-of-run pulse from the BIST FSM
- done_shifting  out  1  last bit of the current pattern is being shifted
- no_more_tests  out  1  current pattern is the final one
- sig_valid  out  1  verdict available
- pass  out  1  signature matched GOLDEN
- fail  out  1  signature mismatched GOLDEN

Function
REQ-006 SHALL hold a 32-bit serial MISR.
- On shift: sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ {31'b0, scan_out}.
- POLY = 32'h04C1_1DB7.
REQ-007 SHALL hold bit_cnt (0..CHAIN_LEN-1) and test_cnt (0..NUM_TESTS-1).
- Widths: $clog2 of each range, minimum 1.
REQ-008 SHALL increment bit_cnt on each shift. At CHAIN_LEN-1, bit_cnt SHALL wrap to 0 and test_cnt SHALL increment in the same cycle.
REQ-009 SHALL saturate test_cnt at NUM_TESTS-1. Further wraps SHALL NOT change test_cnt.
REQ-010 SHALL drive done_shifting = (bit_cnt == CHAIN_LEN-1), decoded from registered state only.
REQ-011 SHALL drive no_more_tests = (test_cnt == NUM_TESTS-1), decoded from registered state only.
REQ-012 On done, SHALL register the compare one cycle later:
- sig_valid=1
- pass = (sig == GOLDEN)
- fail = ~pass
REQ-013 If shift and done coincide, the compare SHALL use the signature that includes the current shift's bit.
REQ-014 Once sig_valid=1, the verdict SHALL be sticky. Further shift or done SHALL be ignored (signature and counters frozen) until init or reset.
REQ-015 init SHALL take priority over shift and done in the same cycle. It SHALL clear sig, bit_cnt, test_cnt, sig_valid, pass and fail.
REQ-016 pass and fail SHALL never both be 1. Both SHALL be 0 whenever sig_valid=0.

Reset
REQ-017 On reset_l=0, the block SHALL asynchronously clear:
- sig=0
- bit_cnt=0
- test_cnt=0
- sig_valid=0, pass=0, fail=0
REQ-018 Reset mid-pattern SHALL discard the partial signature. After reset, done_shifting=0 (CHAIN_LEN>1) and no_more_tests=0 (NUM_TESTS>1).

Configuration
REQ-019 Macro BIST_MISR_DIAG_EN:
- Defined: adds outputs sig_dbg[31:0] (live signature) and fail_test[8:0]. fail_test captures test_cnt at the first pattern boundary where the running signature's low byte is 8'h00, or 9'h1FF if none occurs.
- Undefined: these ports and their registers are absent, and all other behaviour is identical.

Structure
REQ-020 Shared package bist_pkg SHALL hold:
- POLY
- default GOLDEN
- default CHAIN_LEN and NUM_TESTS
- the signature-width constant SIG_W=32
REQ-021 One sub-module, bist_misr32, SHALL contain the MISR register and feedback. Counters, status decode and compare logic SHALL stay in bist_misr_cmp.

Verification
REQ-022 Reset, then hold init=1 for 1 cycle -> all outputs 0; sig=0.
REQ-023 CHAIN_LEN=4, NUM_TESTS=2, scan_out=1 for 4 shifts:
- done_shifting=1 after the 3rd shift.
- After the 4th shift: bit_cnt=0, test_cnt=1, no_more_tests=1.
- Signature = 32'h0000_000F.
REQ-024 With GOLDEN set to the model's signature, run 8 shifts then pulse done -> next cycle sig_valid=1, pass=1, fail=0. Flip one scan_out bit on rerun -> fail=1.
REQ-025 shift and done in the same cycle -> verdict reflects the signature including that bit. A later shift=1 leaves the verdict and sig unchanged.
REQ-026 Assert reset_l=0 after 2 of 4 bits of a pattern -> immediate clear. Restart yields the same signature as a clean run.
REQ-027 init and shift asserted together at bit_cnt=CHAIN_LEN-1 -> counters 0, no test_cnt increment, sig=0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST constants: MISR polynomial, signature width and default run geometry.
package bist_pkg;

  localparam int unsigned SIG_W         = 32;
  localparam logic [SIG_W-1:0] POLY     = 32'h04C1_1DB7;
  localparam logic [SIG_W-1:0] GOLDEN_DEF = 32'h5A17_C3E9;
  localparam int unsigned CHAIN_LEN_DEF = 247;
  localparam int unsigned NUM_TESTS_DEF = 256;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_misr32.sv
// Serial 32-bit MISR: compacts one response bit per enabled cycle.
// sig_nxt_c exposes the value the register takes at the next edge so the
// caller can compare against a signature that includes the current bit.
module bist_misr32
  import bist_pkg::*;
(
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [SIG_W-1:0] sig_nxt_c
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] sig_shift;

  // Feedback shift with polynomial reduction; clear wins over shift.
  always_comb begin
    sig_shift = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ {{(SIG_W-1){1'b0}}, din_i};
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = sig_shift;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o     = sig_q;
  assign sig_nxt_c = sig_d;

endmodule

// File: rtl/bist_misr_cmp.sv
// BIST response checker: MISR compaction, bit/pattern counters, pattern
// status decode and a sticky pass/fail verdict against GOLDEN.
// Optional diagnostics enabled by defining BIST_MISR_DIAG_EN.
module bist_misr_cmp
  import bist_pkg::*;
#(
  parameter int unsigned      CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned      NUM_TESTS = NUM_TESTS_DEF,
  parameter logic [SIG_W-1:0] GOLDEN    = GOLDEN_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             init,
  input  logic             shift,
  input  logic             scan_out,
  input  logic             done,
  output logic             done_shifting,
  output logic             no_more_tests,
  output logic             sig_valid,
  output logic             pass,
  output logic             fail
`ifdef BIST_MISR_DIAG_EN
  ,
  output logic [SIG_W-1:0] sig_dbg,
  output logic [8:0]       fail_test
`endif
);

  localparam int unsigned BW = cnt_w(CHAIN_LEN);
  localparam int unsigned TW = cnt_w(NUM_TESTS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN_LEN - 1);
  localparam logic [TW-1:0] TEST_LAST = TW'(NUM_TESTS - 1);

  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]    test_cnt_q, test_cnt_d;
  logic             sig_valid_q, sig_valid_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             adv_c;
  logic             wrap_c;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] sig_nxt_c;

  // Shifting is frozen once a verdict is held; init overrides everything.
  assign adv_c  = shift & ~sig_valid_q & ~init;
  assign wrap_c = adv_c & (bit_cnt_q == BIT_LAST);

  bist_misr32 u_misr (
    .clk       (clk),
    .reset_l   (reset_l),
    .clr_i     (init),
    .en_i      (adv_c),
    .din_i     (scan_out),
    .sig_o     (sig),
    .sig_nxt_c (sig_nxt_c)
  );

  // Counter advance, pattern saturation and one-shot verdict capture.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    test_cnt_d  = test_cnt_q;
    sig_valid_d = sig_valid_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    if (init) begin
      bit_cnt_d   = '0;
      test_cnt_d  = '0;
      sig_valid_d = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
    end else begin
      if (adv_c) begin
        if (wrap_c) begin
          bit_cnt_d = '0;
          if (test_cnt_q != TEST_LAST) begin
            test_cnt_d = test_cnt_q + TW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      if (done && !sig_valid_q) begin
        sig_valid_d = 1'b1;
        pass_d      = (sig_nxt_c == GOLDEN);
        fail_d      = (sig_nxt_c != GOLDEN);
      end
    end
  end

  // Counter and verdict registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bit_cnt_q   <= '0;
      test_cnt_q  <= '0;
      sig_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      test_cnt_q  <= test_cnt_d;
      sig_valid_q <= sig_valid_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign done_shifting = (bit_cnt_q == BIT_LAST);
  assign no_more_tests = (test_cnt_q == TEST_LAST);
  assign sig_valid     = sig_valid_q;
  assign pass          = pass_q;
  assign fail          = fail_q;

`ifdef BIST_MISR_DIAG_EN
  logic [8:0] fail_test_q, fail_test_d;
  logic       ft_hit_q, ft_hit_d;

  // Latch the first pattern index whose boundary signature has a zero low byte.
  always_comb begin
    fail_test_d = fail_test_q;
    ft_hit_d    = ft_hit_q;
    if (init) begin
      fail_test_d = 9'h1FF;
      ft_hit_d    = 1'b0;
    end else if (wrap_c && !ft_hit_q && (sig_nxt_c[7:0] == 8'h00)) begin
      fail_test_d = 9'(test_cnt_q);
      ft_hit_d    = 1'b1;
    end
  end

  // Diagnostic capture registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      fail_test_q <= 9'h1FF;
      ft_hit_q    <= 1'b0;
    end else begin
      fail_test_q <= fail_test_d;
      ft_hit_q    <= ft_hit_d;
    end
  end

  assign sig_dbg   = sig;
  assign fail_test = fail_test_q;
`else
  logic unused_sig_c;
  assign unused_sig_c = ^sig;
`endif

endmodule

// File: tb/tb_bist_misr_cmp.sv
// Directed bench for bist_misr_cmp with CHAIN_LEN=4, NUM_TESTS=2.
module tb_bist_misr_cmp;

  localparam logic [31:0] TB_GOLDEN = 32'h0000_00B2;

  logic clk;
  logic reset_l;
  logic init;
  logic shift;
  logic scan_out;
  logic done;
  logic done_shifting;
  logic no_more_tests;
  logic sig_valid;
  logic pass;
  logic fail;
`ifdef BIST_MISR_DIAG_EN
  logic [31:0] sig_dbg;
  logic [8:0]  fail_test;
`endif

  int checks;
  int errors;

  bist_misr_cmp #(
    .CHAIN_LEN (4),
    .NUM_TESTS (2),
    .GOLDEN    (TB_GOLDEN)
  ) dut (
    .clk           (clk),
    .reset_l       (reset_l),
    .init          (init),
    .shift         (shift),
    .scan_out      (scan_out),
    .done          (done),
    .done_shifting (done_shifting),
    .no_more_tests (no_more_tests),
    .sig_valid     (sig_valid),
    .pass          (pass),
    .fail          (fail)
`ifdef BIST_MISR_DIAG_EN
    ,
    .sig_dbg       (sig_dbg),
    .fail_test     (fail_test)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic sh, input logic so, input logic dn, input logic in);
    shift    = sh;
    scan_out = so;
    done     = dn;
    init     = in;
    @(posedge clk);
    #1;
    shift    = 1'b0;
    scan_out = 1'b0;
    done     = 1'b0;
    init     = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) step(1'b1, p[i], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({done_shifting, no_more_tests, sig_valid, pass, fail} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000", {done_shifting, no_more_tests, sig_valid, pass, fail});
    end
    reset_l = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({done_shifting, no_more_tests, sig_valid, pass, fail} !== 5'b0) begin
      errors++;
      $display("FAIL init_outputs got %b exp 00000", {done_shifting, no_more_tests, sig_valid, pass, fail});
    end
    checks++;
    if (dut.u_misr.sig_q !== 32'h0) begin
      errors++;
      $display("FAIL init_sig got %h exp 00000000", dut.u_misr.sig_q);
    end
  endtask

  task automatic test_count();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        checks++;
        if (done_shifting !== 1'b0) begin
          errors++;
          $display("FAIL ds_after1 got %b exp 0", done_shifting);
        end
      end
      if (i == 2) begin
        checks++;
        if ({done_shifting, no_more_tests} !== 2'b10) begin
          errors++;
          $display("FAIL ds_after3 got %b exp 10", {done_shifting, no_more_tests});
        end
      end
    end
    checks++;
    if ({dut.bit_cnt_q, dut.test_cnt_q} !== 3'b001) begin
      errors++;
      $display("FAIL cnt_after4 got %b exp 001", {dut.bit_cnt_q, dut.test_cnt_q});
    end
    checks++;
    if ({done_shifting, no_more_tests} !== 2'b01) begin
      errors++;
      $display("FAIL status_after4 got %b exp 01", {done_shifting, no_more_tests});
    end
    checks++;
    if (dut.u_misr.sig_q !== 32'h0000_000F) begin
      errors++;
      $display("FAIL sig_after4 got %h exp 0000000f", dut.u_misr.sig_q);
    end
  endtask

  task automatic test_verdict();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    shift_byte(8'hB2);
    checks++;
    if ({sig_valid, pass, fail} !== 3'b000) begin
      errors++;
      $display("FAIL pre_done got %b exp 000", {sig_valid, pass, fail});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sig_valid, pass, fail} !== 3'b110) begin
      errors++;
      $display("FAIL verdict_pass got %b exp 110", {sig_valid, pass, fail});
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({sig_valid, pass, fail} !== 3'b000) begin
      errors++;
      $display("FAIL init_clears_verdict got %b exp 000", {sig_valid, pass, fail});
    end
    shift_byte(8'hB3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sig_valid, pass, fail} !== 3'b101) begin
      errors++;
      $display("FAIL verdict_fail got %b exp 101", {sig_valid, pass, fail});
    end
  endtask

  task automatic test_coincide();
    logic [7:0] p;
    p = 8'hB2;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 7; i >= 1; i--) step(1'b1, p[i], 1'b0, 1'b0);
    step(1'b1, p[0], 1'b1, 1'b0);
    checks++;
    if ({sig_valid, pass, fail} !== 3'b110) begin
      errors++;
      $display("FAIL coincide_verdict got %b exp 110", {sig_valid, pass, fail});
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut.u_misr.sig_q !== 32'h0000_00B2) begin
      errors++;
      $display("FAIL frozen_sig got %h exp 000000b2", dut.u_misr.sig_q);
    end
    checks++;
    if ({sig_valid, pass, fail, dut.bit_cnt_q, dut.test_cnt_q} !== 6'b110_00_1) begin
      errors++;
      $display("FAIL frozen_state got %b exp 110001", {sig_valid, pass, fail, dut.bit_cnt_q, dut.test_cnt_q});
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut.bit_cnt_q !== 2'd2) begin
      errors++;
      $display("FAIL mid_bitcnt got %0d exp 2", dut.bit_cnt_q);
    end
    #1;
    reset_l = 1'b0;
    #1;
    checks++;
    if ({dut.u_misr.sig_q, dut.bit_cnt_q, dut.test_cnt_q} !== 35'h0) begin
      errors++;
      $display("FAIL async_clear got %h exp 0", {dut.u_misr.sig_q, dut.bit_cnt_q, dut.test_cnt_q});
    end
    @(negedge clk);
    reset_l = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut.u_misr.sig_q !== 32'h0000_000B) begin
      errors++;
      $display("FAIL restart_sig got %h exp 0000000b", dut.u_misr.sig_q);
    end
  endtask

  task automatic test_init_priority();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (done_shifting !== 1'b1) begin
      errors++;
      $display("FAIL prio_setup got %b exp 1", done_shifting);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({dut.u_misr.sig_q, dut.bit_cnt_q, dut.test_cnt_q, done_shifting, no_more_tests} !== 37'h0) begin
      errors++;
      $display("FAIL init_priority got %h exp 0",
               {dut.u_misr.sig_q, dut.bit_cnt_q, dut.test_cnt_q, done_shifting, no_more_tests});
    end
  endtask

  task automatic test_feedback();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut.u_misr.sig_q !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sig_32ones got %h exp ffffffff", dut.u_misr.sig_q);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut.u_misr.sig_q !== 32'hFB3E_E248) begin
      errors++;
      $display("FAIL sig_feedback got %h exp fb3ee248", dut.u_misr.sig_q);
    end
    checks++;
    if ({dut.bit_cnt_q, dut.test_cnt_q, no_more_tests} !== 4'b01_1_1) begin
      errors++;
      $display("FAIL saturate got %b exp 0111", {dut.bit_cnt_q, dut.test_cnt_q, no_more_tests});
    end
`ifdef BIST_MISR_DIAG_EN
    checks++;
    if (sig_dbg !== 32'hFB3E_E248) begin
      errors++;
      $display("FAIL sig_dbg got %h exp fb3ee248", sig_dbg);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_l  = 1'b0;
    init     = 1'b0;
    shift    = 1'b0;
    scan_out = 1'b0;
    done     = 1'b0;
    test_reset();
    test_count();
    test_verdict();
    test_coincide();
    test_reset_mid();
    test_init_priority();
    test_feedback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
